// File: rtl/sync_edge_det.sv
// ============================================================================
// Module   : sync_edge_det
// Brief    : Two-flop synchronizer plus history flop with rise/fall strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

`default_nettype wire

// File: rtl/clk_period_meter.sv
// ============================================================================
// Module   : clk_period_meter
// Brief    : Measures period and high time of a slow async square wave in
//            clk_i cycles; one-cycle valid strobe and stall timeout flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic             clk_i,
    input  logic             sys_rst,
    input  logic             sig_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             timeout_o
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic w_level_unused;
    logic w_rise;
    logic w_fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    sync_edge_det u_sync (
        .clk_i   (clk_i),
        .rst_i   (sys_rst),
        .async_i (sig_i),
        .level_o (w_level_unused),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_lat_d  = hi_lat_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (w_rise) begin
                    state_d  = ST_MEASURE;
                    cnt_d    = C_ONE;
                    hi_lat_d = '0;
                end
            end
            ST_MEASURE: begin
                if (w_fall) begin
                    hi_lat_d = cnt_q;
                end
                // A rise arriving on the saturation cycle still counts as a valid period.
                if (w_rise) begin
                    period_d  = cnt_q;
                    high_d    = hi_lat_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = C_ONE;
                    hi_lat_d  = '0;
                end else if (cnt_q == C_TIMEOUT) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_lat_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_lat_q  <= hi_lat_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_period_meter.sv
// ============================================================================
// Module   : tb_clk_period_meter
// Brief    : Directed self-checking bench for clk_period_meter (TIMEOUT_CYC=20).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clk_period_meter;

    localparam int C_CNT_W   = 16;
    localparam int C_TIMEOUT = 20;

    logic               clk;
    logic               sys_rst;
    logic               sig;
    logic [C_CNT_W-1:0] period;
    logic [C_CNT_W-1:0] high;
    logic               valid;
    logic               timeout;

    int n_checks = 0;
    int n_errors = 0;

    int          vcount = 0;
    int          dbl    = 0;
    logic        prev_v = 1'b0;
    logic [31:0] last_p = '0;
    logic [31:0] last_h = '0;
    int          base;

    clk_period_meter #(
        .CNT_W       (C_CNT_W),
        .TIMEOUT_CYC (C_TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .sys_rst   (sys_rst),
        .sig_i     (sig),
        .period_o  (period),
        .high_o    (high),
        .valid_o   (valid),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Valid-strobe monitor: counts pulses, captures values, flags multi-cycle pulses.
    always @(negedge clk) begin
        if (valid) begin
            vcount = vcount + 1;
            if (prev_v) dbl = dbl + 1;
            last_p = 32'(period);
            last_h = 32'(high);
        end
        prev_v = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            sig = 1'b1;
            tick(h);
            sig = 1'b0;
            tick(l);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        sig     = 1'b0;

        // Reset held while the input toggles
        for (int i = 0; i < 5; i++) begin
            sig = ~sig;
            tick(1);
            check("rst_valid",   32'(valid),   32'd0);
            check("rst_period",  32'(period),  32'd0);
            check("rst_high",    32'(high),    32'd0);
            check("rst_timeout", 32'(timeout), 32'd0);
        end
        sig = 1'b0;
        tick(1);
        sys_rst = 1'b0;
        tick(3);
        check("rst_no_valid", 32'(vcount), 32'd0);

        // 4 high / 4 low: first rise only arms
        wave(4, 4, 1);
        check("div_first_rise", 32'(vcount), 32'd0);
        wave(4, 4, 4);
        check("div_count",  32'(vcount), 32'd4);
        check("div_period", last_p, 32'd8);
        check("div_high",   last_h, 32'd4);

        // 3 high / 7 low
        base = vcount;
        wave(3, 7, 4);
        check("duty_count",  32'(vcount - base), 32'd4);
        check("duty_period", last_p, 32'd10);
        check("duty_high",   last_h, 32'd3);

        // Single rise then stuck low
        base = vcount;
        sig = 1'b1;
        tick(3);
        sig = 1'b0;
        tick(19);
        check("to_not_yet", 32'(timeout), 32'd0);
        tick(1);
        check("to_set", 32'(timeout), 32'd1);
        check("to_period_kept", 32'(period), 32'd10);
        tick(5);
        check("to_valid_count", 32'(vcount - base), 32'd1);

        // Resume: first rise re-arms, next one measures and clears timeout
        base = vcount;
        wave(4, 4, 1);
        check("rearm_no_valid", 32'(vcount - base), 32'd0);
        check("rearm_to_held",  32'(timeout), 32'd1);
        wave(4, 4, 1);
        check("resume_count",  32'(vcount - base), 32'd1);
        check("resume_period", last_p, 32'd8);
        check("resume_to_clr", 32'(timeout), 32'd0);

        // Period exactly TIMEOUT_CYC: rise wins
        base = vcount;
        wave(10, 10, 3);
        check("bnd20_count",   32'(vcount - base), 32'd3);
        check("bnd20_period",  last_p, 32'd20);
        check("bnd20_high",    last_h, 32'd10);
        check("bnd20_timeout", 32'(timeout), 32'd0);

        // Period TIMEOUT_CYC+1: timeout, second rise only arms
        base = vcount;
        wave(10, 11, 2);
        check("bnd21_count",   32'(vcount - base), 32'd1);
        check("bnd21_timeout", 32'(timeout), 32'd1);
        check("bnd21_period",  32'(period), 32'd20);
        tick(30);

        // Mid-period reset
        base = vcount;
        wave(4, 4, 2);
        check("mid_pre_count",  32'(vcount - base), 32'd1);
        check("mid_pre_period", last_p, 32'd8);
        sig = 1'b1;
        tick(4);
        sig = 1'b0;
        tick(1);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        check("mid_rst_period",  32'(period),  32'd0);
        check("mid_rst_high",    32'(high),    32'd0);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        tick(2);
        base = vcount;
        wave(4, 4, 1);
        check("mid_arm_only", 32'(vcount - base), 32'd0);
        wave(4, 4, 1);
        check("mid_count",  32'(vcount - base), 32'd1);
        check("mid_period", last_p, 32'd8);
        check("mid_high",   last_h, 32'd4);

        check("valid_single_cycle", 32'(dbl), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
